imem_fetch_port: RTL and testbench

Parametrised, pipelined instruction memory with a valid/ready fetch interface, placed between the PC/fetch stage and the decode stage. It returns a DATA_WIDTH instruction per accepted byte address after a configurable LATENCY. Illegal accesses get an error code instead of silent data. The block also has a program-load write port and a flush input for branch redirects.

---
 rtl/imem_fetch_port.sv | 111 +++++++++++
 tb/tb_imem_fetch_port.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_port.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imem_fetch_port: pipelined instruction memory with valid/ready fetch,     |
// | program-load write port and flush. Revision 1.0                           |
// +--------------------------------------------------------------------------+
module imem_fetch_port #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 256,
   parameter int LATENCY    = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [ADDR_WIDTH-1:0]    req_addr,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [DATA_WIDTH-1:0]    rsp_instr,
   output logic [1:0]               rsp_err,
   input  logic                     load_en,
   input  logic [$clog2(DEPTH)-1:0] load_addr,
   input  logic [DATA_WIDTH-1:0]    load_data,
   input  logic                     flush
);

   localparam int c_AS = $clog2(DATA_WIDTH / 8);
   localparam int c_AW = $clog2(DEPTH);

   localparam logic [1:0] c_ERR_OK    = 2'b00;
   localparam logic [1:0] c_ERR_ALIGN = 2'b01;
   localparam logic [1:0] c_ERR_RANGE = 2'b10;

   // Storage powers up cleared and is never touched by rst_n.
   logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: '0};

   logic                  r_vld   [LATENCY];
   logic [DATA_WIDTH-1:0] r_instr [LATENCY];
   logic [1:0]            r_err   [LATENCY];

   logic                  w_adv;
   logic                  w_accept;
   logic                  w_misaligned;
   logic                  w_out_of_range;
   logic [c_AW-1:0]       w_index;
   logic [1:0]            w_err;
   logic [DATA_WIDTH-1:0] w_instr;

   assign w_misaligned = |req_addr[c_AS-1:0];
   assign w_index      = req_addr[c_AS+c_AW-1:c_AS];

   generate
      if (ADDR_WIDTH > c_AS + c_AW) begin : g_range_check
         assign w_out_of_range = |req_addr[ADDR_WIDTH-1:c_AS+c_AW];
      end else begin : g_no_range_check
         assign w_out_of_range = 1'b0;
      end
   endgenerate

   always_comb begin
      w_err   = c_ERR_OK;
      w_instr = r_mem[w_index];
      if (w_misaligned) begin
         w_err   = c_ERR_ALIGN;
         w_instr = '0;
      end else if (w_out_of_range) begin
         w_err   = c_ERR_RANGE;
         w_instr = '0;
      end
   end

   assign w_adv     = !r_vld[LATENCY-1] || rsp_ready;
   assign req_ready = w_adv && !load_en && !flush;
   assign w_accept  = req_valid && req_ready;

   always_ff @(posedge clk) begin
      if (load_en) begin
         r_mem[load_addr] <= load_data;
      end
   end

   // Data is captured at acceptance so later loads cannot disturb in-flight fetches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LATENCY; i++) begin
            r_vld[i]   <= 1'b0;
            r_instr[i] <= '0;
            r_err[i]   <= c_ERR_OK;
         end
      end else if (flush) begin
         for (int i = 0; i < LATENCY; i++) begin
            r_vld[i] <= 1'b0;
         end
      end else if (w_adv) begin
         for (int i = LATENCY - 1; i > 0; i--) begin
            r_vld[i]   <= r_vld[i-1];
            r_instr[i] <= r_instr[i-1];
            r_err[i]   <= r_err[i-1];
         end
         r_vld[0]   <= w_accept;
         r_instr[0] <= w_instr;
         r_err[0]   <= w_err;
      end
   end

   assign rsp_valid = r_vld[LATENCY-1];
   assign rsp_instr = r_instr[LATENCY-1];
   assign rsp_err   = r_err[LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_port.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_imem_fetch_port: drives a LATENCY=1 and a LATENCY=2 instance in turn   |
// | against a queue-based reference model. Revision 1.0                       |
// +--------------------------------------------------------------------------+
module tb_imem_fetch_port;

   typedef struct {
      logic [31:0] ins;
      logic [1:0]  err;
      int          acc;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_en;
   logic [7:0]  load_addr;
   logic [31:0] load_data;
   logic        flush;
   logic [1:0]  req_valid;
   logic [1:0]  rsp_ready;
   logic [63:0] req_addr [2];

   logic        req_ready0, req_ready1, rsp_valid0, rsp_valid1;
   logic [31:0] rsp_instr0, rsp_instr1;
   logic [1:0]  rsp_err0, rsp_err1;

   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   int          sel = 0;
   bit          strict = 1'b0;
   bit          hold_chk = 1'b0;
   logic [31:0] hold_ins;
   logic [1:0]  hold_err;
   logic [31:0] mem_m [256];
   ent_t        q [$];

   always #5 clk = ~clk;

   imem_fetch_port #(.ADDR_WIDTH(64), .DATA_WIDTH(32), .DEPTH(256), .LATENCY(1)) u_dut_l1 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready0),
      .req_addr(req_addr[0]), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready[0]),
      .rsp_instr(rsp_instr0), .rsp_err(rsp_err0), .load_en(load_en),
      .load_addr(load_addr), .load_data(load_data), .flush(flush));

   imem_fetch_port #(.ADDR_WIDTH(64), .DATA_WIDTH(32), .DEPTH(256), .LATENCY(2)) u_dut_l2 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready1),
      .req_addr(req_addr[1]), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready[1]),
      .rsp_instr(rsp_instr1), .rsp_err(rsp_err1), .load_en(load_en),
      .load_addr(load_addr), .load_data(load_data), .flush(flush));

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s (L=%0d cyc=%0d): got 0x%0h, want 0x%0h", tag, sel + 1, cyc, act, exp);
      end
   endtask

   // Reference behaviour: 4-byte words, 256 of them, misalignment reported first.
   function automatic ent_t model(input logic [63:0] a);
      ent_t e;
      e.acc = 0;
      if (a % 64'd4 != 64'd0) begin
         e.ins = 32'h0; e.err = 2'b01;
      end else if (a / 64'd4 >= 64'd256) begin
         e.ins = 32'h0; e.err = 2'b10;
      end else begin
         e.ins = mem_m[a / 64'd4]; e.err = 2'b00;
      end
      return e;
   endfunction

   function automatic logic [63:0] rand_addr();
      int k = $urandom_range(9);
      if (k < 7)      return 64'($urandom_range(255)) * 64'd4;
      else if (k < 8) return 64'($urandom_range(1023)) * 64'd4 + 64'($urandom_range(3, 1));
      else if (k < 9) return 64'($urandom_range(1023, 256)) * 64'd4;
      else            return {32'($urandom), 32'($urandom)} & ~64'd3;
   endfunction

   // Called at a falling edge with inputs already driven; models the next rising edge.
   task automatic step();
      logic        vld, rdy, exp_rdy;
      logic [31:0] ins;
      logic [1:0]  er;
      int          lat;
      ent_t        e;
      #1;
      lat = sel + 1;
      rdy = (sel == 0) ? req_ready0 : req_ready1;
      vld = (sel == 0) ? rsp_valid0 : rsp_valid1;
      ins = (sel == 0) ? rsp_instr0 : rsp_instr1;
      er  = (sel == 0) ? rsp_err0   : rsp_err1;
      if (hold_chk) begin
         check("hold_valid", 64'(vld), 64'd1);
         check("hold_instr", 64'(ins), 64'(hold_ins));
         check("hold_err",   64'(er),  64'(hold_err));
      end
      exp_rdy = (!vld || rsp_ready[sel]) && !load_en && !flush;
      check("req_ready", 64'(rdy), 64'(exp_rdy));
      if (vld && q.size() == 0) begin
         check("spurious_valid", 64'(vld), 64'd0);
      end else if (vld && strict) begin
         check("latency", 64'(cyc - q[0].acc), 64'(lat - 1));
      end else if (!vld && strict && q.size() > 0 && cyc - q[0].acc >= lat - 1) begin
         check("late_valid", 64'(vld), 64'd1);
      end
      if (vld && rsp_ready[sel] && !flush && q.size() > 0) begin
         e = q.pop_front();
         check("rsp_instr", 64'(ins), 64'(e.ins));
         check("rsp_err",   64'(er),  64'(e.err));
      end
      hold_chk = vld && !rsp_ready[sel] && !flush;
      hold_ins = ins;
      hold_err = er;
      if (flush) q.delete();
      if (req_valid[sel] && exp_rdy) begin
         e = model(req_addr[sel]);
         e.acc = cyc + 1;
         q.push_back(e);
      end
      if (load_en) mem_m[load_addr] = load_data;
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic fetch(input logic [63:0] a);
      req_valid[sel] = 1'b1;
      req_addr[sel]  = a;
      step();
      req_valid[sel] = 1'b0;
   endtask

   task automatic load(input logic [7:0] w, input logic [31:0] d);
      load_en = 1'b1; load_addr = w; load_data = d;
      step();
      load_en = 1'b0;
   endtask

   task automatic drain();
      req_valid[sel] = 1'b0;
      rsp_ready[sel] = 1'b1;
      flush = 1'b0;
      load_en = 1'b0;
      for (int i = 0; i < sel + 4; i++) step();
      check("drain_empty", 64'(q.size()), 64'd0);
   endtask

   task automatic directed(input int s);
      sel = s;
      rsp_ready[sel] = 1'b1;
      strict = 1'b1;
      fetch(64'd0); fetch(64'd4); fetch(64'd8); fetch(64'd12);
      fetch(64'd6); fetch(64'd1024); fetch(64'h1_0000_0000);
      drain();
      strict = 1'b0;
      // Backpressure for five cycles with a request stream pending.
      rsp_ready[sel] = 1'b0;
      for (int i = 0; i < 5; i++) fetch(64'(i * 4));
      drain();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem_m[i] = 32'h0;
      rst_n = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0; flush = 1'b0;
      req_valid = 2'b00; rsp_ready = 2'b11;
      req_addr[0] = '0; req_addr[1] = '0;
      #1;
      check("rst_valid_l1", 64'(rsp_valid0), 64'd0);
      check("rst_valid_l2", 64'(rsp_valid1), 64'd0);
      check("rst_instr_l2", 64'(rsp_instr1), 64'd0);
      check("rst_err_l2",   64'(rsp_err1),   64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      load(8'd0, 32'h0000_0033);
      load(8'd1, 32'h00A5_0533);
      load(8'd2, 32'h4005_8533);

      directed(0);
      directed(1);

      // Flush two in-flight requests on the two-stage pipe.
      sel = 1;
      rsp_ready[1] = 1'b0;
      fetch(64'd0); fetch(64'd8);
      flush = 1'b1;
      step();
      flush = 1'b0;
      rsp_ready[1] = 1'b1;
      step(); step();
      fetch(64'd4);
      drain();

      // Load collides with a presented request.
      for (int s = 0; s < 2; s++) begin
         sel = s;
         req_valid[sel] = 1'b1; req_addr[sel] = 64'd0;
         load(8'd1, 32'hDEAD_BEEF);
         req_valid[sel] = 1'b0;
         fetch(64'd4);
         drain();
      end

      // Asynchronous reset mid-stream keeps storage.
      sel = 0;
      rsp_ready[0] = 1'b0;
      fetch(64'd8);
      step();
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_valid", 64'(rsp_valid0), 64'd0);
      check("rst_async_instr", 64'(rsp_instr0), 64'd0);
      q.delete();
      hold_chk = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      rsp_ready[0] = 1'b1;
      fetch(64'd0);
      drain();

      for (int s = 0; s < 2; s++) begin
         sel = s;
         for (int n = 0; n < 400; n++) begin
            req_valid[sel] = ($urandom_range(9) < 7);
            req_addr[sel]  = rand_addr();
            rsp_ready[sel] = ($urandom_range(9) < 7);
            load_en   = ($urandom_range(19) == 0);
            load_addr = 8'($urandom_range(255));
            load_data = $urandom;
            flush     = ($urandom_range(29) == 0);
            step();
         end
         drain();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
